// File: rtl/normalize_scheduler_pkg.sv
// Shared definitions for the normalise-datapath scheduler.
//   DIR_W   packed direction width ({x, y}, each COMP_W bits, two's complement)
//   COMP_W  width of one direction component
//   D_W     width of the target length operand
//   ST_*    scheduler state encoding
package normalize_scheduler_pkg;

  localparam int DIR_W  = 22;
  localparam int COMP_W = 11;
  localparam int D_W    = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // A zero vector has no direction; it bypasses the datapath.
  function automatic logic dir_is_zero(input logic [DIR_W-1:0] dir);
    return (dir == '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   eligible  requesters that may be served this cycle
//   rr_ptr    highest-priority index (search starts here, upward with wrap)
//   onehot    one-hot winner, zero when nothing is eligible
//   idx       binary winner index
//   any       at least one requester is eligible
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      // Wrap at N_REQ, not at 2^ID_W, so non-power-of-two counts work.
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!any && eligible[cand]) begin
        any          = 1'b1;
        idx          = ID_W'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/normalize_scheduler.sv
// Shares one fixed-latency direction-normalise datapath between N_REQ
// ray units.
//   clk, rst           clock, asynchronous active-high reset
//   req/req_dir/req_d  per-requester request level, packed {x,y}, length
//   gnt                one-hot single-cycle accept pulse
//   busy               datapath occupied
//   norm_dir/norm_d    registered operands to the datapath, stable while busy
//   norm_x/norm_y      datapath result, valid NORM_LAT cycles after operands
//   resp_valid/resp_id/resp_x/resp_y  tagged result strobe (values hold)
// Zero vectors never occupy the datapath: they are answered with (0,0) in
// the same cycle as their grant.
module normalize_scheduler
  import normalize_scheduler_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int NORM_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DIR_W-1:0] req_dir,
  input  logic [N_REQ*D_W-1:0]   req_d,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [DIR_W-1:0]       norm_dir,
  output logic [D_W-1:0]         norm_d,
  input  logic [COMP_W-1:0]      norm_x,
  input  logic [COMP_W-1:0]      norm_y,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic [COMP_W-1:0]      resp_x,
  output logic [COMP_W-1:0]      resp_y
);

  localparam int CNT_W = $clog2(NORM_LAT + 1);

  logic [0:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] cnt;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] win_onehot;
  logic [ID_W-1:0]  win_idx;
  logic             win_any;
  logic [DIR_W-1:0] win_dir;
  logic [D_W-1:0]   win_d;
  logic [ID_W-1:0]  ptr_next;

  // The requester currently seeing its grant is still holding req this
  // cycle; masking it prevents a double grant.
  assign eligible = req & ~gnt;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .onehot   (win_onehot),
    .idx      (win_idx),
    .any      (win_any)
  );

  assign win_dir  = req_dir[int'(win_idx)*DIR_W +: DIR_W];
  assign win_d    = req_d[int'(win_idx)*D_W +: D_W];
  assign ptr_next = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      cnt        <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      norm_dir   <= '0;
      norm_d     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_x     <= '0;
      resp_y     <= '0;
    end else begin
      gnt        <= '0;
      resp_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (win_any) begin
          gnt    <= win_onehot;
          rr_ptr <= ptr_next;
          if (dir_is_zero(win_dir)) begin
            resp_valid <= 1'b1;
            resp_id    <= win_idx;
            resp_x     <= '0;
            resp_y     <= '0;
          end else begin
            norm_dir <= win_dir;
            norm_d   <= win_d;
            id_q     <= win_idx;
            cnt      <= CNT_W'(NORM_LAT);
            busy     <= 1'b1;
            state    <= ST_WAIT;
          end
        end
      end else begin
        // Operands are untouched here; the datapath result is taken on
        // the last cycle of the latency window.
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          resp_valid <= 1'b1;
          resp_id    <= id_q;
          resp_x     <= norm_x;
          resp_y     <= norm_y;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_normalize_scheduler.sv
module tb_normalize_scheduler;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int LAT   = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*22-1:0]  req_dir;
  logic [N_REQ*8-1:0]   req_d;
  logic [N_REQ-1:0]     gnt;
  logic                 busy;
  logic [21:0]          norm_dir;
  logic [7:0]           norm_d;
  logic [10:0]          norm_x;
  logic [10:0]          norm_y;
  logic                 resp_valid;
  logic [ID_W-1:0]      resp_id;
  logic [10:0]          resp_x;
  logic [10:0]          resp_y;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  normalize_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .NORM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dir(req_dir), .req_d(req_d),
    .gnt(gnt), .busy(busy), .norm_dir(norm_dir), .norm_d(norm_d),
    .norm_x(norm_x), .norm_y(norm_y), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_x(resp_x), .resp_y(resp_y)
  );

  // Reference normalise: scale (x,y) to length d, truncating toward zero.
  function automatic logic [21:0] nfunc(input logic [21:0] dir, input logic [7:0] d);
    int x, y;
    real len;
    logic [10:0] rx, ry;
    x = int'($signed(dir[21:11]));
    y = int'($signed(dir[10:0]));
    if (x == 0 && y == 0) return '0;
    len = $sqrt(real'(x * x + y * y));
    rx = 11'($rtoi(real'(x) * real'(d) / len));
    ry = 11'($rtoi(real'(y) * real'(d) / len));
    return {rx, ry};
  endfunction

  // Datapath model: result appears LAT cycles after operands become stable.
  logic [21:0] dp_pipe [LAT-1];
  always @(posedge clk) begin
    dp_pipe[0] <= nfunc(norm_dir, norm_d);
    for (int i = 1; i < LAT - 1; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign {norm_x, norm_y} = dp_pipe[LAT-2];

  // Operand stability flag: any change while the datapath is busy.
  int          stab_err = 0;
  logic        last_busy = 1'b0;
  logic [21:0] last_dir = '0;
  logic [7:0]  last_d = '0;
  always @(negedge clk) begin
    if (busy && last_busy && (norm_dir !== last_dir || norm_d !== last_d))
      stab_err <= stab_err + 1;
    last_busy <= busy;
    last_dir  <= norm_dir;
    last_d    <= norm_d;
  end

  task automatic set_dir(input int i, input logic signed [10:0] x,
                         input logic signed [10:0] y, input logic [7:0] d);
    req_dir[22*i +: 22] = {x, y};
    req_d[8*i +: 8]     = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (gnt !== '0) begin fails++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_rv got=%b exp=0", resp_valid); end
    tests++; if ({resp_id, resp_x, resp_y} !== '0) begin fails++;
      $display("FAIL reset_resp got=%0h/%0h/%0h exp=0", resp_id, resp_x, resp_y); end
    tests++; if ({norm_dir, norm_d} !== '0) begin fails++;
      $display("FAIL reset_norm got=%0h/%0h exp=0", norm_dir, norm_d); end
    repeat (3) @(negedge clk);
    tests++; if (gnt !== '0 || resp_valid !== 1'b0) begin fails++;
      $display("FAIL idle_quiet got gnt=%b rv=%b exp 0/0", gnt, resp_valid); end
  endtask

  task automatic test_single();
    do_reset();
    set_dir(0, 11'sd300, 11'sd400, 8'd100);
    req = 4'b0001;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      tests++; if (gnt !== ((c == 1) ? 4'b0001 : 4'b0000)) begin fails++;
        $display("FAIL single_gnt c=%0d got=%b", c, gnt); end
      tests++; if (busy !== (c >= 1 && c <= 4)) begin fails++;
        $display("FAIL single_busy c=%0d got=%b", c, busy); end
      tests++; if (resp_valid !== (c == 5)) begin fails++;
        $display("FAIL single_rv c=%0d got=%b", c, resp_valid); end
      if (c == 5) begin
        tests++; if (resp_id !== 2'd0 || resp_x !== 11'd60 || resp_y !== 11'd80) begin fails++;
          $display("FAIL single_resp got id=%0d x=%0d y=%0d exp 0/60/80", resp_id, resp_x, resp_y); end
      end
      if (gnt[0]) req[0] = 1'b0;
    end
  endtask

  // Runs right after test_single: operands still hold (300,400,100).
  task automatic test_zero();
    set_dir(2, 11'sd0, 11'sd0, 8'd55);
    req = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests++; if (gnt !== ((c == 1) ? 4'b0100 : 4'b0000)) begin fails++;
        $display("FAIL zero_gnt c=%0d got=%b", c, gnt); end
      tests++; if (resp_valid !== (c == 1)) begin fails++;
        $display("FAIL zero_rv c=%0d got=%b", c, resp_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy c=%0d got=%b", c, busy); end
      if (c == 1) begin
        tests++; if (resp_id !== 2'd2 || resp_x !== '0 || resp_y !== '0) begin fails++;
          $display("FAIL zero_resp got id=%0d x=%0d y=%0d exp 2/0/0", resp_id, resp_x, resp_y); end
        tests++; if (norm_dir !== {11'd300, 11'd400} || norm_d !== 8'd100) begin fails++;
          $display("FAIL zero_norm got=%0h/%0d", norm_dir, norm_d); end
      end
      if (gnt[2]) req[2] = 1'b0;
    end
  endtask

  task automatic test_mixed();
    logic [21:0] e2;
    do_reset();
    set_dir(1, 11'sd0, 11'sd0, 8'd9);
    set_dir(2, -11'sd512, 11'sd511, 8'd200);
    e2 = nfunc({-11'sd512, 11'sd511}, 8'd200);
    req = 4'b0110;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tests++; if (gnt !== ((c == 1) ? 4'b0010 : (c == 2) ? 4'b0100 : 4'b0000)) begin fails++;
        $display("FAIL mixed_gnt c=%0d got=%b", c, gnt); end
      tests++; if (resp_valid !== (c == 1 || c == 6)) begin fails++;
        $display("FAIL mixed_rv c=%0d got=%b", c, resp_valid); end
      tests++; if (busy !== (c >= 2 && c <= 5)) begin fails++;
        $display("FAIL mixed_busy c=%0d got=%b", c, busy); end
      if (c == 1) begin
        tests++; if (resp_id !== 2'd1 || {resp_x, resp_y} !== '0) begin fails++;
          $display("FAIL mixed_resp1 got id=%0d x=%0d y=%0d", resp_id, resp_x, resp_y); end
      end
      if (c == 6) begin
        tests++; if (resp_id !== 2'd2 || {resp_x, resp_y} !== e2) begin fails++;
          $display("FAIL mixed_resp2 got id=%0d xy=%0h exp 2/%0h", resp_id, {resp_x, resp_y}, e2); end
      end
      req = req & ~gnt;
    end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] eg;
    int id;
    do_reset();
    for (int i = 0; i < N_REQ; i++)
      set_dir(i, 11'(100 * (i + 1)), 11'(-50 * (i + 1)), 8'(50 + i));
    req = 4'b1111;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      eg = ((c - 1) % 5 == 0) ? 4'(1 << (((c - 1) / 5) % 4)) : 4'b0000;
      tests++; if (gnt !== eg) begin fails++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      tests++; if (resp_valid !== (c % 5 == 0)) begin fails++;
        $display("FAIL rr_rv c=%0d got=%b", c, resp_valid); end
      if (c % 5 == 0) begin
        id = (c / 5 - 1) % 4;
        tests++; if (resp_id !== ID_W'(id) || {resp_x, resp_y} !== nfunc(req_dir[22*id +: 22], req_d[8*id +: 8])) begin
          fails++; $display("FAIL rr_resp c=%0d got id=%0d xy=%0h exp id=%0d", c, resp_id, {resp_x, resp_y}, id); end
      end
    end
    req = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_dir(i, 11'sd7, -11'sd3, 8'd40);
    req = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (gnt[0]) req[0] = 1'b0;
    end
    rst = 1'b1;
    #1;
    tests++; if ({gnt, busy, resp_valid, resp_id, resp_x, resp_y, norm_dir, norm_d} !== '0) begin fails++;
      $display("FAIL midrst_outputs got gnt=%b busy=%b rv=%b id=%0d x=%0h y=%0h nd=%0h d=%0h",
               gnt, busy, resp_valid, resp_id, resp_x, resp_y, norm_dir, norm_d); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests++; if (resp_valid !== 1'b0 || gnt !== '0) begin fails++;
        $display("FAIL midrst_quiet c=%0d got rv=%b gnt=%b", c, resp_valid, gnt); end
    end
    req = 4'b1111;
    @(negedge clk);
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL midrst_next got=%b exp=0001", gnt); end
    req = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random();
    int granted = 0;
    int cyc = 0;
    int due = 0;
    int rr_m = 0;
    int w;
    int cidx;
    int r;
    logic pend = 1'b0;
    logic idle;
    logic bypass;
    logic exp_rv;
    logic [ID_W-1:0] exp_id = '0;
    logic [21:0] exp_val = '0;
    logic [ID_W-1:0] byp_id;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] eg;
    logic signed [10:0] rx, ry;
    do_reset();
    while ((granted < 200 || pend) && cyc < 20000) begin
      elig = req & ~gnt;
      idle = !pend;
      @(negedge clk);
      cyc++;
      w = -1;
      if (idle) begin
        for (int k = 0; k < N_REQ; k++) begin
          cidx = (rr_m + k) % N_REQ;
          if (w < 0 && elig[cidx]) w = cidx;
        end
      end
      eg = (w >= 0) ? 4'(1 << w) : 4'b0000;
      tests++; if (gnt !== eg) begin fails++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg); end
      exp_rv = 1'b0;
      bypass = 1'b0;
      byp_id = '0;
      if (pend && due == cyc) begin
        exp_rv = 1'b1;
        pend = 1'b0;
      end
      if (w >= 0) begin
        granted++;
        rr_m = (w + 1) % N_REQ;
        if (req_dir[22*w +: 22] == '0) begin
          bypass = 1'b1;
          byp_id = ID_W'(w);
          exp_rv = 1'b1;
        end else begin
          pend    = 1'b1;
          due     = cyc + LAT;
          exp_id  = ID_W'(w);
          exp_val = nfunc(req_dir[22*w +: 22], req_d[8*w +: 8]);
        end
      end
      tests++; if (resp_valid !== exp_rv) begin fails++;
        $display("FAIL rand_rv cyc=%0d got=%b exp=%b", cyc, resp_valid, exp_rv); end
      if (exp_rv && resp_valid === 1'b1) begin
        tests++;
        if (bypass) begin
          if (resp_id !== byp_id || {resp_x, resp_y} !== '0) begin fails++;
            $display("FAIL rand_byp cyc=%0d got id=%0d xy=%0h exp id=%0d xy=0", cyc, resp_id, {resp_x, resp_y}, byp_id); end
        end else if (resp_id !== exp_id || {resp_x, resp_y} !== exp_val) begin fails++;
          $display("FAIL rand_resp cyc=%0d got id=%0d xy=%0h exp id=%0d xy=%0h", cyc, resp_id, {resp_x, resp_y}, exp_id, exp_val);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (granted >= 200) req[i] = 1'b0;
        else if (gnt[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(63) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(2) == 0) begin
          r = $urandom_range(7);
          case (r)
            0: begin rx = 11'sd0; ry = 11'sd0; end
            1: begin rx = -11'sd512; ry = 11'sd511; end
            2: begin rx = -11'sd1024; ry = 11'sd1023; end
            3: begin rx = 11'sd1023; ry = 11'sd0; end
            default: begin
              rx = 11'($urandom);
              ry = 11'($urandom);
              if (rx == 0 && ry == 0) rx = 11'sd1;
            end
          endcase
          set_dir(i, rx, ry, 8'($urandom));
          req[i] = 1'b1;
        end
      end
    end
    tests++; if (granted < 200 || pend) begin fails++;
      $display("FAIL rand_timeout granted=%0d pend=%b exp 200/0", granted, pend); end
    tests++; if (stab_err != 0) begin fails++;
      $display("FAIL operand_stability got=%0d changes exp=0", stab_err); end
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    req_dir = '0;
    req_d   = '0;
    test_reset();
    test_single();
    test_zero();
    test_mixed();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/normalize_scheduler.md
Name: normalize_scheduler

Overview:
- Shares one two-dimensional direction-normalise datapath (packed 11-bit signed x,y in; 11-bit x,y out; fixed latency NORM_LAT; no valid/handshake of its own) between N_REQ ray units.
- Performs round-robin arbitration, drives the datapath operands, holds them stable for the full latency, and returns a tagged result to the winner.
- Zero vectors bypass the datapath and return (0,0) immediately.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of response tag, clog2(N_REQ)
- NORM_LAT, 4, cycles from stable operands to valid datapath output (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request level; held until own gnt bit seen
- req_dir  in  N_REQ*22  per-requester direction, slice i = [22*i+21:22*i], x in [21:11], y in [10:0]
- req_d  in  N_REQ*8  per-requester target length
- gnt  out  N_REQ  one-hot, single-cycle accept pulse
- busy  out  1  datapath occupied (WAIT state)
- norm_dir  out  22  operand to datapath, registered
- norm_d  out  8  operand to datapath, registered
- norm_x  in  11  datapath result x
- norm_y  in  11  datapath result y
- resp_valid  out  1  single-cycle result strobe
- resp_id  out  ID_W  index of requester owning the result
- resp_x  out  11  normalised x
- resp_y  out  11  normalised y

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, cnt=0, gnt=0, busy=0, resp_valid=0, resp_id=0, resp_x=0, resp_y=0, norm_dir=0, norm_d=0. An in-flight operation is discarded; no response is produced afterwards.
- States: IDLE, WAIT.
- IDLE, edge ending cycle t:
  - eligible = req & ~gnt; the requester currently seeing gnt is masked.
  - If eligible != 0, winner w = first set bit at or after rr_ptr, searching upward with wrap. Then gnt<=onehot(w) and rr_ptr<=(w+1) mod N_REQ.
  - If dir slice of w == 0: resp_valid<=1, resp_id<=w, resp_x/resp_y<=0, state stays IDLE, norm_* unchanged.
  - Else: norm_dir/norm_d<=slices of w, id_q<=w, cnt<=NORM_LAT, busy<=1, state<=WAIT.
  - If eligible == 0: no change.
- WAIT: gnt=0 after its pulse. cnt decrements each cycle. On the edge where cnt==1: resp_x<=norm_x, resp_y<=norm_y, resp_id<=id_q, resp_valid<=1, busy<=0, state<=IDLE.
- Timing: request seen in cycle 0 -> gnt high in cycle 1 -> resp_valid high in cycle NORM_LAT+1. Zero-bypass response is high in cycle 1, together with gnt.
- Throughput: one datapath operation per NORM_LAT+1 cycles; one zero-bypass per cycle, alternating requesters.
- gnt and resp_valid are each 1 cycle wide. resp_* hold their values until the next response; they are not cleared.
- norm_dir/norm_d are held constant throughout WAIT. Their values after WAIT are don't-care for the datapath.
- A request dropped before its gnt is never served. req changes during WAIT are ignored until IDLE.
- resp_valid in the same cycle as a new gnt is legal; the two are independent strobes.
- N_REQ not a power of two: rr_ptr wraps at N_REQ, not at 2^ID_W.

Decomposition:
- Shared package holds constants DIR_W=22, COMP_W=11, D_W=8 and the state encoding (IDLE=0, WAIT=1).
- One sub-module, rr_arbiter:
  - Parameter N_REQ; inputs eligible and rr_ptr; outputs onehot, idx, any.
  - Purely combinational; pointer register stays in the scheduler.

Test Plan:
- Single request: req=0001, dir x=300,y=400, d=100, NORM_LAT=4, model returns (60,80) after 4 cycles -> gnt=0001 in cycle 1; busy cycles 1-4; resp_valid in cycle 5 with id=0, x=60, y=80.
- All four requesting continuously from cycle 0 -> gnt order 0,1,2,3,0 at cycles 1,6,11,16,21; resp ids in the same order; never two gnt bits set.
- Zero vector: req=0100, dir=0 -> gnt=0100 and resp_valid with id=2, x=0, y=0, both in cycle 1; busy stays 0; norm_dir unchanged.
- Mixed: requester 1 zero, requester 2 nonzero, both asserted -> id 1 is answered in cycle 1 (bypass). Requester 2 is granted in cycle 2 and answered in cycle 6 (cycle 2 + NORM_LAT).
- Operand stability: datapath model flags any change of norm_dir/norm_d during busy -> no flag over 200 random requests, with negative components (x=-512, y=511).
- Reset mid-operation: assert rst in cycle 3 of WAIT -> all outputs are 0 in the same cycle; after release, no resp_valid until a new req; the next grant goes to requester 0.
